adder_result_checker: RTL and testbench

//  Downstream stage of the MyTopLevel adder: consumes the operands driven into io_A/io_B and
//  the adder result io_X, rebuilds the expected sum, aligns it to the adder latency and

---
 rtl/adder_check_pkg.sv | 15 +
 rtl/expect_delay_line.sv | 38 +++
 rtl/adder_result_checker.sv | 122 ++++++++++++
 tb/tb_adder_result_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_check_pkg.sv
// adder_check_pkg: shared FSM states, default sizing and the reference sum used by the checker
package adder_check_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_LATENCY = 1;
    localparam int DEF_CNT_W   = 24;

    // Full-width sum; callers truncate to their own W so the carry out is discarded
    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/expect_delay_line.sv
// expect_delay_line: shifts {valid, expected} pairs by LATENCY cycles to line up with the adder output
module expect_delay_line
    import adder_check_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [LATENCY-1:0] r_valid;
    logic [W-1:0]       r_data [LATENCY];

    // Valid tags are flushed on clear so stale samples never reach the comparator
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < LATENCY; i++) r_valid[i] <= r_valid[i-1];
        end
    end

    // Data needs no clear: it is only looked at when its tag is set
    always_ff @(posedge clk) begin
        r_data[0] <= i_data;
        for (int i = 1; i < LATENCY; i++) r_data[i] <= r_data[i-1];
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: runs a fixed-length campaign comparing adder results against rebuilt sums
module adder_result_checker
    import adder_check_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_checks,
    input  logic             i_in_valid,
    input  logic [W-1:0]     i_in_a,
    input  logic [W-1:0]     i_in_b,
    input  logic [W-1:0]     i_dut_x,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_check_count,
    output logic [CNT_W-1:0] o_mismatch_count,
    output logic [CNT_W-1:0] o_first_err_index,
    output logic [W-1:0]     o_first_err_exp,
    output logic [W-1:0]     o_first_err_act
);

    state_t           r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_acc;
    logic [3:0]       r_dcnt;
    logic [CNT_W-1:0] r_check;
    logic [CNT_W-1:0] r_mis;
    logic [CNT_W-1:0] r_ferr_idx;
    logic [W-1:0]     r_ferr_exp;
    logic [W-1:0]     r_ferr_act;

    logic             w_start;
    logic             w_accept;
    logic             w_clr;
    logic [W-1:0]     w_exp;
    logic             w_dl_valid;
    logic [W-1:0]     w_dl_exp;
    logic             w_mism;

    assign w_start  = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept = (r_state == S_RUN) && i_in_valid;
    assign w_clr    = reset || w_start;
    assign w_exp    = W'(exp_sum(32'(i_in_a), 32'(i_in_b)));
    assign w_mism   = w_dl_valid && (i_dut_x != w_dl_exp);

    expect_delay_line #(.W(W), .LATENCY(LATENCY)) u_dl (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_valid (w_accept),
        .i_data  (w_exp),
        .o_valid (w_dl_valid),
        .o_data  (w_dl_exp)
    );

    // Campaign sequencing: accept num_checks samples, then let the last one drain out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_acc   <= '0;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_num   <= i_num_checks;
                        r_acc   <= '0;
                        r_dcnt  <= '0;
                        r_state <= (i_num_checks == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_in_valid) begin
                        r_acc <= r_acc + 1'b1;
                        if (r_acc + 1'b1 == r_num) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_dcnt <= r_dcnt + 4'd1;
                    if (r_dcnt == 4'(LATENCY - 1)) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result bookkeeping on each emerging tag; first mismatch is frozen until the next campaign
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_check    <= '0;
            r_mis      <= '0;
            r_ferr_idx <= '0;
            r_ferr_exp <= '0;
            r_ferr_act <= '0;
        end else if (w_dl_valid) begin
            r_check <= r_check + 1'b1;
            if (w_mism) begin
                if (~&r_mis) r_mis <= r_mis + 1'b1;
                if (r_mis == '0) begin
                    r_ferr_idx <= r_check;
                    r_ferr_exp <= w_dl_exp;
                    r_ferr_act <= i_dut_x;
                end
            end
        end
    end

    assign o_busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done            = (r_state == S_DONE);
    assign o_pass            = o_done && (r_mis == '0);
    assign o_check_count     = r_check;
    assign o_mismatch_count  = r_mis;
    assign o_first_err_index = r_ferr_idx;
    assign o_first_err_exp   = r_ferr_exp;
    assign o_first_err_act   = r_ferr_act;

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: scoreboarded campaigns against a faultable adder model
module tb_adder_result_checker;

    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int CW  = 24;

    logic          clk = 0;
    logic          reset = 1;
    logic          start = 0;
    logic [CW-1:0] num_checks = '0;
    logic          in_valid = 0;
    logic          bad = 0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [W-1:0]  dut_x;
    logic          o_busy, o_done, o_pass;
    logic [CW-1:0] o_check_count, o_mismatch_count, o_first_err_index;
    logic [W-1:0]  o_first_err_exp, o_first_err_act;

    adder_result_checker #(.W(W), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_start           (start),
        .i_num_checks      (num_checks),
        .i_in_valid        (in_valid),
        .i_in_a            (in_a),
        .i_in_b            (in_b),
        .i_dut_x           (dut_x),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_pass            (o_pass),
        .o_check_count     (o_check_count),
        .o_mismatch_count  (o_mismatch_count),
        .o_first_err_index (o_first_err_index),
        .o_first_err_exp   (o_first_err_exp),
        .o_first_err_act   (o_first_err_act)
    );

    always #5 clk = ~clk;

    // Adder under observation: LAT-cycle pipelined sum, off by one when bad is set
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= in_a + in_b + W'(bad);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dut_x = pipe[LAT-1];

    typedef struct {
        int cnt;
        int mis;
        int fidx;
        int fexp;
        int fact;
    } res_t;

    res_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outputs_zero"},
            int'(|{o_busy, o_done, o_pass, o_check_count, o_mismatch_count,
                   o_first_err_index, o_first_err_exp, o_first_err_act}), 0);
    endtask

    // Monitor: every rising done is matched against the oldest predicted campaign result
    res_t m_e;
    logic prev_done = 0;
    always @(negedge clk) begin
        if (o_done && !prev_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e = sbq.pop_front();
                chk("check_count", int'(o_check_count), m_e.cnt);
                chk("mismatch_count", int'(o_mismatch_count), m_e.mis);
                chk("pass", int'(o_pass), int'(m_e.mis == 0));
                chk("first_err_index", int'(o_first_err_index), m_e.fidx);
                chk("first_err_exp", int'(o_first_err_exp), m_e.fexp);
                chk("first_err_act", int'(o_first_err_act), m_e.fact);
            end
        end
        prev_done <= o_done;
    end

    // mode 0: a=b=n%200, 1: a=b=199, 2: random; bad_at -1 none, -2 every sample, else one index
    task automatic campaign(input int num, input int mode, input int bad_at, input bit gaps, input bit poke);
        int   qa[$];
        int   qb[$];
        int   qbad[$];
        res_t e;
        int   a, b, bd, k;
        e = '{num, 0, 0, 0, 0};
        for (int i = 0; i < num; i++) begin
            a  = (mode == 0) ? i % 200 : (mode == 1) ? 199 : int'($urandom_range(255, 0));
            b  = (mode == 0) ? i % 200 : (mode == 1) ? 199 : int'($urandom_range(255, 0));
            bd = int'(bad_at == -2 || bad_at == i);
            if (bd != 0) begin
                if (e.mis == 0) begin
                    e.fidx = i;
                    e.fexp = (a + b) % 256;
                    e.fact = (a + b + 1) % 256;
                end
                e.mis++;
            end
            qa.push_back(a);
            qb.push_back(b);
            qbad.push_back(bd);
        end
        sbq.push_back(e);
        start      = 1;
        num_checks = CW'(num);
        @(posedge clk) #1;
        start = 0;
        for (int i = 0; i < num; i++) begin
            in_valid = 1;
            in_a     = W'(qa[i]);
            in_b     = W'(qb[i]);
            bad      = qbad[i][0];
            start    = poke && (i == num / 2);
            if (poke && i == num / 2) num_checks = CW'(7);
            @(posedge clk) #1;
            start    = 0;
            in_valid = 0;
            bad      = 0;
            if (gaps && i != num - 1) begin
                repeat (2) begin
                    in_a = W'($urandom);
                    in_b = W'($urandom);
                    @(posedge clk) #1;
                end
            end
        end
        k = 0;
        while (!o_done && k < 50) begin
            in_valid = (k < 2);
            bad      = 1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            start    = poke && (num == 0) && (k == 0);
            if (start) num_checks = CW'(5);
            @(posedge clk) #1;
            k++;
        end
        in_valid = 0;
        bad      = 0;
        start    = 0;
        chk("done_latency", k, LAT);
        in_valid = 1;
        repeat (3) @(posedge clk) #1;
        in_valid = 0;
        chk("held_check_count", int'(o_check_count), num);
        chk("held_done", int'(o_done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 0;
        @(posedge clk) #1;
        campaign(400, 0, -1, 0, 0);
        campaign(30, 1, -1, 0, 0);
        campaign(30, 1, -2, 0, 0);
        campaign(100, 2, 37, 0, 0);
        campaign(10, 2, -1, 1, 1);
        campaign(0, 2, -1, 0, 1);
        start      = 1;
        num_checks = CW'(100);
        @(posedge clk) #1;
        start = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(posedge clk) #1;
        end
        in_valid = 0;
        repeat (LAT) @(posedge clk) #1;
        chk("mid_run_check_count", int'(o_check_count), 50);
        chk("mid_run_busy", int'(o_busy), 1);
        reset = 1;
        @(posedge clk) #1;
        chk_zero("abort");
        reset = 0;
        @(posedge clk) #1;
        campaign(20, 2, 5, 0, 0);
        repeat (2) @(posedge clk) #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
